// File: rtl/cla_mp_sequencer.sv
// Multi-precision add/subtract sequencer: one WIDTH-bit carry-lookahead slice
// is reused over WORDS cycles, least-significant slice first.

module cla_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;
  logic             prod;

  // Every carry is a flat sum of generate terms gated by the propagates above
  // them, so no carry depends on a lower computed carry.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    prod = 1'b0;
    c[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = cin;
      for (int j = 0; j <= i; j++) c[i+1] = c[i+1] & p[j];
      for (int j = 0; j <= i; j++) begin
        prod = g[j];
        for (int k = j + 1; k <= i; k++) prod = prod & p[k];
        c[i+1] = c[i+1] | prod;
      end
    end
    sum  = p ^ c[WIDTH-1:0];
    cout = c[WIDTH];
  end
endmodule

module cla_mp_sequencer #(
  parameter int WIDTH = 32,
  parameter int WORDS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   sub_i,
  input  logic                   carry_i,
  input  logic [WORDS*WIDTH-1:0] opa_i,
  input  logic [WORDS*WIDTH-1:0] opb_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [WORDS*WIDTH-1:0] result_o,
  output logic                   carry_o,
  output logic [1:0]             state_o
);
  localparam int N    = WORDS * WIDTH;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: a start is taken only on an edge where start_i=1 and the block
  // is idle; done_o then pulses for exactly one cycle WORDS edges later.
  state_t            state_q, state_d;
  logic [N-1:0]      opa_q, opb_q, result_q;
  logic              sub_q, carry_q;
  logic [IDXW-1:0]   idx_q;
  logic [WIDTH-1:0]  slice_a, slice_b, slice_sum;
  logic              slice_cout;
  logic              accept, last;

  assign slice_a = opa_q[idx_q*WIDTH +: WIDTH];
  assign slice_b = opb_q[idx_q*WIDTH +: WIDTH] ^ {WIDTH{sub_q}};

  cla_adder #(.WIDTH(WIDTH)) u_add (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  assign accept = (state_q == S_IDLE) && start_i;
  assign last   = (idx_q == IDXW'(WORDS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Index is held on the last slice so it never produces an extra write.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      opa_q    <= '0;
      opb_q    <= '0;
      sub_q    <= 1'b0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      opa_q    <= opa_i;
      opb_q    <= opb_i;
      sub_q    <= sub_i;
      carry_q  <= sub_i ? 1'b1 : carry_i;
      idx_q    <= '0;
      result_q <= '0;
    end else if (state_q == S_RUN) begin
      result_q[idx_q*WIDTH +: WIDTH] <= slice_sum;
      carry_q <= slice_cout;
      if (!last) idx_q <= idx_q + IDXW'(1);
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign done_o   = (state_q == S_DONE);
  assign result_o = result_q;
  assign carry_o  = carry_q;
  assign state_o  = state_q;
endmodule
